chunk_assembly_ctrl: RTL
========================

# chunk_assembly_ctrl

- Assembles a raster pixel stream into CELL_SIZE-row by CHUNK_SIZE-cell video chunks using two ping-pong banks.
- Presents each completed chunk in processing-chunk order, through one instance of the chunk transposer, to the upscaling datapath over a valid/ready handshake.
- Sits between the HDMI-input line stream and the per-cell processing engines.
- Sequences the transposer: decides when its input is complete and stable, and when the downstream has consumed it.

## Interface
- CELL_SIZE, 2: pixels per cell edge (rows per chunk, columns per cell).
- CHUNK_SIZE, 3: cells per chunk row; line width W = CHUNK_SIZE*CELL_SIZE pixels.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- s_pixel  in  pixel (24 b)  input pixel.
- s_valid  in  1  s_pixel valid.
- s_last  in  1  marks the last pixel of a line.
- s_ready  out  1  block can accept a pixel.
- m_chunk  out  pixel[CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0]  processing chunk, indexed [cell][row][col].
- m_valid  out  1  m_chunk valid.
- m_ready  in  1  downstream accepts m_chunk.
- line_err  out  1  sticky; s_last misplaced since reset.
- chunk_count  out  16  chunks delivered (m_valid & m_ready), wraps 0xFFFF→0.

## Operation
- State:
  - bank[0:1], each pixel[CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0] indexed [row][cell][col].
  - full[1:0], wr_bank, rd_bank, col (0..W-1), row (0..CELL_SIZE-1).
- s_ready = !full[wr_bank]. s_ready is 0 while reset is asserted.
- Accept = s_valid & s_ready. An accepted pixel is written to bank[wr_bank][row][col/CELL_SIZE][col%CELL_SIZE].
- Column/row sequencing:
  - col < W-1 and s_last = 0: col++.
  - col == W-1: col ← 0.
    - If row < CELL_SIZE-1: row++.
    - Otherwise: row ← 0, full[wr_bank] ← 1, wr_bank toggles.
- s_last errors:
  - Missing s_last at col == W-1: line ends anyway; line_err ← 1.
  - Early s_last (col < W-1): the partial chunk in wr_bank is discarded. col ← 0, row ← 0, full unchanged, line_err ← 1. This resyncs to the next line.
- m_valid = full[rd_bank].
- m_chunk is the combinational transpose of bank[rd_bank]: m_chunk[c][r][k] = bank[rd_bank][r][c][k]. It is stable while m_valid = 1.
- Handshake: on m_valid & m_ready, full[rd_bank] ← 0, rd_bank toggles, chunk_count++.
- Simultaneous fill-complete on one bank and drain of the other in the same cycle: both take effect.
- A bank never receives writes while full.

## Timing
- Reset values: full = 0, wr_bank = rd_bank = 0, col = row = 0, line_err = 0, chunk_count = 0, m_valid = 0. s_ready = 1 from the first edge after reset deassertion.
- Latency: last pixel of a chunk accepted at edge N → m_valid = 1 after edge N (visible in cycle N+1).
- Throughput: one pixel per cycle sustained if each chunk is drained within W*CELL_SIZE cycles.
  - Both banks full → s_ready = 0 until a drain. s_ready rises the cycle after the m_valid & m_ready edge.
- m_valid, once high, stays high with m_chunk unchanged until accepted. No combinational path m_ready → s_ready.
- Reset mid-operation: partial and full chunks are discarded, and there is no spurious m_valid after release.

## Structure
- Shared package upscaler_pkg holds:
  - typedef pixel (struct of 8-bit R, G, B; 24 b).
  - Default CELL_SIZE / CHUNK_SIZE localparams.
- The only sub-module is chunk_transposer, instantiated once on the bank[rd_bank] mux output.
- The bank mux is a 2:1 select; the banks are plain flop arrays.

## Test plan
Defaults apply (W=6, 12 pixels per chunk). Pixel index i = row*6 + x, value 24'hA0B0C0 + i.
1. Single chunk, m_ready = 1: stream 12 pixels with s_last on x=5.
   - m_valid = 1 one cycle after the 12th accept.
   - m_chunk[1][0][1] = 24'hA0B0C3; m_chunk[2][1][0] = 24'hA0B0CA.
   - chunk_count = 1.
2. Backpressure, m_ready = 0, 36 pixels offered:
   - Two chunks assemble; s_ready = 0 after the 24th accept.
   - Raise m_ready for one cycle → first chunk delivered; s_ready = 1 next cycle; order preserved.
3. Sustained stream of 120 pixels, m_ready = 1: s_ready never drops; chunk_count = 10; every chunk matches the transpose rule.
4. Early s_last at x=3 of row 1:
   - line_err = 1; no m_valid.
   - The following 12 clean pixels yield a correct chunk (chunk_count = 1).
5. Missing s_last at x=5: line_err = 1; chunk still emitted after 12 pixels.
6. Reset asserted after 7 pixels and with one full bank pending:
   - All outputs return to reset values; m_valid stays 0.
   - The next 12 pixels produce exactly one chunk.

Source files
------------

// File: rtl/upscaler_pkg.sv
// Shared types and default geometry for the upscaler datapath.
// A pixel is 24-bit RGB with R in the most significant byte.
package upscaler_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel;

    localparam int DEF_CELL_SIZE  = 2;
    localparam int DEF_CHUNK_SIZE = 3;

    // Index width that stays legal for a dimension of size 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_transposer.sv
// Reorders a raster-ordered chunk [row][cell][col] into processing order
// [cell][row][col]. Purely combinational.
module chunk_transposer
    import upscaler_pkg::*;
#(
    parameter int CELL_SIZE  = DEF_CELL_SIZE,
    parameter int CHUNK_SIZE = DEF_CHUNK_SIZE
) (
    input  pixel [CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0] bank_i,
    output pixel [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] chunk_o
);

    always_comb begin
        for (int c = 0; c < CHUNK_SIZE; c++) begin
            for (int r = 0; r < CELL_SIZE; r++) begin
                for (int k = 0; k < CELL_SIZE; k++) begin
                    chunk_o[c][r][k] = bank_i[r][c][k];
                end
            end
        end
    end

endmodule

// File: rtl/chunk_assembly_ctrl.sv
// Assembles raster lines into CELL_SIZE x (CHUNK_SIZE cells) chunks in two
// ping-pong banks and hands each finished chunk downstream in cell order.
module chunk_assembly_ctrl
    import upscaler_pkg::*;
#(
    parameter int CELL_SIZE  = DEF_CELL_SIZE,
    parameter int CHUNK_SIZE = DEF_CHUNK_SIZE
) (
    input  logic  clk,
    input  logic  reset,
    input  pixel  s_pixel,
    input  logic  s_valid,
    input  logic  s_last,
    output logic  s_ready,
    output pixel [CHUNK_SIZE-1:0][CELL_SIZE-1:0][CELL_SIZE-1:0] m_chunk,
    output logic  m_valid,
    input  logic  m_ready,
    output logic  line_err,
    output logic [15:0] chunk_count
);

    localparam int CW = idx_w(CHUNK_SIZE);
    localparam int SW = idx_w(CELL_SIZE);

    typedef pixel [CELL_SIZE-1:0][CHUNK_SIZE-1:0][CELL_SIZE-1:0] bank_t;

    bank_t [1:0]   bank_q, bank_d;
    logic  [1:0]   full_q, full_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [CW-1:0] cell_q, cell_d;     // column split as cell index ...
    logic [SW-1:0] sub_q, sub_d;       // ... and column within the cell
    logic [SW-1:0] row_q, row_d;
    logic          err_q, err_d;
    logic [15:0]   count_q, count_d;

    logic accept;
    logic drain;
    logic line_end;
    bank_t rd_bank;

    assign s_ready  = !full_q[wr_q] && !reset;
    assign m_valid  = full_q[rd_q];
    assign accept   = s_valid && s_ready;
    assign drain    = m_valid && m_ready;
    assign line_end = (cell_q == CW'(CHUNK_SIZE - 1)) && (sub_q == SW'(CELL_SIZE - 1));
    assign rd_bank  = bank_q[rd_q];

    assign line_err    = err_q;
    assign chunk_count = count_q;

    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        bank_d  = bank_q;
        full_d  = full_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cell_d  = cell_q;
        sub_d   = sub_q;
        row_d   = row_q;
        err_d   = err_q;
        count_d = count_q;

        if (accept) begin
            bank_d[wr_q][row_q][cell_q][sub_q] = s_pixel;
            if (line_end) begin
                cell_d = '0;
                sub_d  = '0;
                if (!s_last) err_d = 1'b1;
                if (row_q == SW'(CELL_SIZE - 1)) begin
                    row_d        = '0;
                    full_d[wr_q] = 1'b1;
                    wr_d         = !wr_q;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else if (s_last) begin
                // Early line end: drop the partial chunk and restart on the next line.
                cell_d = '0;
                sub_d  = '0;
                row_d  = '0;
                err_d  = 1'b1;
            end else if (sub_q == SW'(CELL_SIZE - 1)) begin
                sub_d  = '0;
                cell_d = cell_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end

        // Fill and drain always target different banks, so both may apply.
        if (drain) begin
            full_d[rd_q] = 1'b0;
            rd_d         = !rd_q;
            count_d      = count_q + 16'd1;
        end
    end

    // NOTE: the banks are cleared on reset too, so nothing from before a
    // reset can ever reappear on m_chunk.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q  <= '0;
            full_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cell_q  <= '0;
            sub_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            bank_q  <= bank_d;
            full_q  <= full_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cell_q  <= cell_d;
            sub_q   <= sub_d;
            row_q   <= row_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    chunk_transposer #(
        .CELL_SIZE (CELL_SIZE),
        .CHUNK_SIZE(CHUNK_SIZE)
    ) u_transposer (
        .bank_i (rd_bank),
        .chunk_o(m_chunk)
    );

endmodule
